// File: rtl/elastic_rr_arbiter.sv
// Round-robin merge of NUM_IN valid/ready channels onto one registered output slot,
// with an optional burst hold of up to MAX_BURST consecutive grants per input.
module elastic_rr_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_IN-1:0]                               en_mask,
  input  logic [NUM_IN*DATA_WIDTH-1:0]                    din,
  input  logic [NUM_IN-1:0]                               din_v,
  output logic [NUM_IN-1:0]                               din_r,
  output logic [DATA_WIDTH-1:0]                           dout,
  output logic                                            dout_v,
  input  logic                                            dout_r,
  output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0]  dout_sel
);

  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [NUM_IN-1:0]     elig;
  logic [SEL_W-1:0]      last_q;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_v;
  logic                  hold;
  logic                  load;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] grant_data;

  // (base + k) mod NUM_IN, valid for base < NUM_IN and k <= NUM_IN
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return SEL_W'(s);
  endfunction

  assign load = !dout_v || dout_r;

  // Grant: keep the holder inside its burst, otherwise scan from last+1 with last scanned last
  always_comb begin
    elig      = din_v & en_mask;
    hold      = (cnt_q != '0) && (cnt_q < CNT_W'(MAX_BURST)) && elig[last_q];
    grant_v   = 1'b0;
    grant_idx = last_q;
    if (hold) begin
      grant_v = 1'b1;
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        if (elig[wrap_add(last_q, k)]) begin
          grant_v   = 1'b1;
          grant_idx = wrap_add(last_q, k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    din_r = '0;
    if (rst_n && grant_v && load) din_r[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_v   <= 1'b0;
      dout_sel <= '0;
      last_q   <= SEL_W'(NUM_IN - 1);
      cnt_q    <= '0;
    end else if (load) begin
      if (grant_v) begin
        dout     <= grant_data;
        dout_sel <= grant_idx;
        dout_v   <= 1'b1;
        last_q   <= grant_idx;
        cnt_q    <= hold ? cnt_q + 1'b1 : CNT_W'(1);
      end else begin
        dout_v <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Directed table-driven bench: pure round-robin, burst and non-power-of-two arbiters.
module tb_elastic_rr_arbiter;

  typedef struct {
    int          dut;       // 0: 4-in burst 1, 1: 4-in burst 3, 2: 3-in burst 1
    logic [3:0]  en;
    logic [3:0]  v;
    logic        r;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [1:0]  exp_sel;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_rr, rst_bu, rst_n3;
  logic [3:0]   en_rr, v_rr, rdy_rr, en_bu, v_bu, rdy_bu;
  logic [2:0]   en_n3, v_n3, rdy_n3;
  logic [127:0] din_rr, din_bu;
  logic [95:0]  din_n3;
  logic [31:0]  dout_rr, dout_bu, dout_n3;
  logic         dv_rr, dv_bu, dv_n3, dr_rr, dr_bu, dr_n3;
  logic [1:0]   sel_rr, sel_bu, sel_n3;

  elastic_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst_n(rst_rr), .en_mask(en_rr), .din(din_rr), .din_v(v_rr),
    .din_r(rdy_rr), .dout(dout_rr), .dout_v(dv_rr), .dout_r(dr_rr), .dout_sel(sel_rr));

  elastic_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .MAX_BURST(3)) u_bu (
    .clk(clk), .rst_n(rst_bu), .en_mask(en_bu), .din(din_bu), .din_v(v_bu),
    .din_r(rdy_bu), .dout(dout_bu), .dout_v(dv_bu), .dout_r(dr_bu), .dout_sel(sel_bu));

  elastic_rr_arbiter #(.NUM_IN(3), .DATA_WIDTH(32), .MAX_BURST(1)) u_n3 (
    .clk(clk), .rst_n(rst_n3), .en_mask(en_n3), .din(din_n3), .din_v(v_n3),
    .din_r(rdy_n3), .dout(dout_n3), .dout_v(dv_n3), .dout_r(dr_n3), .dout_sel(sel_n3));

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int dut, input logic [3:0] en, input logic [3:0] v, input logic r,
                     input logic [3:0] rdy, input logic ev, input logic [1:0] sel,
                     input logic [31:0] d);
    vec_t t;
    t.dut = dut; t.en = en; t.v = v; t.r = r;
    t.exp_rdy = rdy; t.exp_v = ev; t.exp_sel = sel; t.exp_dout = d;
    tbl.push_back(t);
  endtask

  // Drive at the falling edge, compare 1 time unit later, then advance to the next falling edge
  task automatic run_row(input int i);
    vec_t        t;
    logic [3:0]  a_rdy;
    logic        a_v;
    logic [1:0]  a_sel;
    logic [31:0] a_d;
    t = tbl[i];
    case (t.dut)
      0:       begin en_rr = t.en;      v_rr = t.v;      dr_rr = t.r; end
      1:       begin en_bu = t.en;      v_bu = t.v;      dr_bu = t.r; end
      default: begin en_n3 = t.en[2:0]; v_n3 = t.v[2:0]; dr_n3 = t.r; end
    endcase
    #1;
    case (t.dut)
      0:       begin a_rdy = rdy_rr;         a_v = dv_rr; a_sel = sel_rr; a_d = dout_rr; end
      1:       begin a_rdy = rdy_bu;         a_v = dv_bu; a_sel = sel_bu; a_d = dout_bu; end
      default: begin a_rdy = {1'b0, rdy_n3}; a_v = dv_n3; a_sel = sel_n3; a_d = dout_n3; end
    endcase
    check("din_r",    i, 32'(a_rdy), 32'(t.exp_rdy));
    check("dout_v",   i, 32'(a_v),   32'(t.exp_v));
    check("dout_sel", i, 32'(a_sel), 32'(t.exp_sel));
    check("dout",     i, a_d,        t.exp_dout);
    @(negedge clk);
  endtask

  int rr_end, bu_end, n3_mid;

  initial begin
    rst_rr = 1'b0; rst_bu = 1'b0; rst_n3 = 1'b0;
    en_rr = 4'hF; v_rr = 4'hF; dr_rr = 1'b1;
    en_bu = 4'hF; v_bu = 4'h0; dr_bu = 1'b1;
    en_n3 = 3'h7; v_n3 = 3'h7; dr_n3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_rr[i*32 +: 32] = 32'hA0 + 32'(i);
      din_bu[i*32 +: 32] = 32'hB0 + 32'(i);
    end
    for (int i = 0; i < 3; i++) din_n3[i*32 +: 32] = 32'hC0 + 32'(i);

    // Pure round-robin, backpressure, masking, idle and single-source cases
    add(0, 4'hF, 4'hF, 1, 4'b0001, 0, 0, 32'h0);
    add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 32'hA0);
    add(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 32'hA1);
    add(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 32'hA2);
    add(0, 4'hF, 4'hF, 1, 4'b0001, 1, 3, 32'hA3);
    for (int i = 0; i < 5; i++) add(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0, 32'hA0);
    add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 32'hA0);
    add(0, 4'b1011, 4'hF, 1, 4'b1000, 1, 1, 32'hA1);
    add(0, 4'b1011, 4'hF, 1, 4'b0001, 1, 3, 32'hA3);
    add(0, 4'b1011, 4'hF, 1, 4'b0010, 1, 0, 32'hA0);
    add(0, 4'b1011, 4'hF, 1, 4'b1000, 1, 1, 32'hA1);
    add(0, 4'hF, 4'h0, 1, 4'b0000, 1, 3, 32'hA3);
    add(0, 4'hF, 4'h0, 1, 4'b0000, 0, 3, 32'hA3);
    add(0, 4'hF, 4'b0100, 0, 4'b0100, 0, 3, 32'hA3);
    add(0, 4'hF, 4'h0, 0, 4'b0000, 1, 2, 32'hA2);
    add(0, 4'hF, 4'b0010, 0, 4'b0000, 1, 2, 32'hA2);
    add(0, 4'hF, 4'b0010, 1, 4'b0010, 1, 2, 32'hA2);
    add(0, 4'hF, 4'h0, 1, 4'b0000, 1, 1, 32'hA1);
    add(0, 4'hF, 4'b0010, 1, 4'b0010, 0, 1, 32'hA1);
    add(0, 4'hF, 4'h0, 1, 4'b0000, 1, 1, 32'hA1);
    add(0, 4'hF, 4'h0, 1, 4'b0000, 0, 1, 32'hA1);
    rr_end = tbl.size();

    // Burst of 3, early drop, lone-source restart, holder masked
    add(1, 4'hF, 4'b0110, 1, 4'b0010, 0, 0, 32'h0);
    add(1, 4'hF, 4'b0110, 1, 4'b0010, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0110, 1, 4'b0010, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0110, 1, 4'b0100, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0110, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0110, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0110, 1, 4'b0010, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0110, 1, 4'b0010, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0100, 1, 4'b0100, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0100, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0100, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0100, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0100, 1, 4'b0100, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0001, 1, 4'b0001, 1, 2, 32'hB2);
    add(1, 4'hF, 4'b0011, 1, 4'b0001, 1, 0, 32'hB0);
    add(1, 4'b1110, 4'b0011, 1, 4'b0010, 1, 0, 32'hB0);
    add(1, 4'b1110, 4'b0011, 1, 4'b0010, 1, 1, 32'hB1);
    add(1, 4'hF, 4'h0, 1, 4'b0000, 1, 1, 32'hB1);
    add(1, 4'hF, 4'b0010, 1, 4'b0010, 0, 1, 32'hB1);
    bu_end = tbl.size();

    // Three inputs: wrap 2 -> 0, then restart after a mid-stream reset
    add(2, 4'h7, 4'h7, 1, 4'b0001, 0, 0, 32'h0);
    add(2, 4'h7, 4'h7, 1, 4'b0010, 1, 0, 32'hC0);
    add(2, 4'h7, 4'h7, 1, 4'b0100, 1, 1, 32'hC1);
    add(2, 4'h7, 4'h7, 1, 4'b0001, 1, 2, 32'hC2);
    add(2, 4'h7, 4'h7, 1, 4'b0010, 1, 0, 32'hC0);
    n3_mid = tbl.size();
    add(2, 4'h7, 4'h7, 1, 4'b0001, 0, 0, 32'h0);
    add(2, 4'h7, 4'h7, 1, 4'b0010, 1, 0, 32'hC0);

    #3;
    check("reset_din_r",    -1, 32'(rdy_rr), 32'h0);
    check("reset_dout_v",   -1, 32'(dv_rr),  32'h0);
    check("reset_dout_sel", -1, 32'(sel_rr), 32'h0);
    check("reset_dout",     -1, dout_rr,     32'h0);

    @(negedge clk);
    rst_rr = 1'b1;
    for (int i = 0; i < rr_end; i++) run_row(i);

    rst_bu = 1'b1;
    for (int i = rr_end; i < bu_end; i++) run_row(i);

    rst_n3 = 1'b1;
    for (int i = bu_end; i < n3_mid; i++) run_row(i);

    // Asynchronous reset while a word is held
    #2;
    check("midreset_pre_v", -2, 32'(dv_n3), 32'h1);
    rst_n3 = 1'b0;
    #1;
    check("midreset_dout_v",   -2, 32'(dv_n3),  32'h0);
    check("midreset_din_r",    -2, 32'(rdy_n3), 32'h0);
    check("midreset_dout_sel", -2, 32'(sel_n3), 32'h0);
    check("midreset_dout",     -2, dout_n3,     32'h0);
    @(negedge clk);
    rst_n3 = 1'b1;
    for (int i = n3_mid; i < tbl.size(); i++) run_row(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
